mult_share_ctrl: RTL and testbench

//   Shares one combinational 16x16 unsigned array multiplier (arraymult_16bit, instantiated

---
 rtl/mult_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_mult_share_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
//   Shares one external combinational 16x16 unsigned array multiplier among NREQ
//   requesters. Each operation goes through three steps:
//     1. A round-robin arbiter picks one requester.
//     2. The block registers that requester's operands onto mul_a/mul_b and waits
//        MULT_LAT edges so the ripple array can settle.
//     3. It captures the product into a single-entry response buffer and holds it
//        there until the consumer takes it.
//   Only one operation is in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active low
//   req_valid    [NREQ]     requester i has operands pending
//   req_ready    [NREQ]     requester i accepted this cycle (one-hot or zero, combinational)
//   req_a/req_b  [NREQ*16]  operands, requester i at [16*i+15:16*i]
//   mul_a/mul_b  [16]       registered operands driven to the multiplier
//   mul_product  [32]       product returned by the multiplier
//   rsp_valid    result available
//   rsp_ready    consumer accepts result
//   rsp_id       [IDW]      requester that owns rsp_product
//   rsp_product  [32]       registered product
//   busy         high whenever the controller is not idle

module mult_share_ctrl #(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 3,
  parameter int IDW      = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_a,
  input  logic [NREQ*16-1:0]   req_b,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [31:0]          mul_product,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_product,
  output logic                 busy
);

  // The settle counter only needs to hold MULT_LAT-1.
  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  win_idx;
  logic            win_found;
  logic            accept;
  int              cand;

  // Round-robin scan. The search starts one past the last winner, so a
  // requester that keeps req_valid high waits behind at most NREQ-1 others.
  // NOTE: every variable written in always_comb is given a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDW'(cand);
      end
    end
  end

  // Operands are taken only while idle. The winner's ready is a pure function
  // of the current req_valid, so it never depends on what ready itself does.
  assign accept = (state == IDLE) && win_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (win_found) state_next = SETTLE;
      SETTLE:  if (cnt == '0) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      cnt         <= '0;
      last_grant  <= IDW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mul_a      <= req_a[16*int'(win_idx) +: 16];
            mul_b      <= req_b[16*int'(win_idx) +: 16];
            rsp_id     <= win_idx;
            last_grant <= win_idx;
            cnt        <= CW'(MULT_LAT - 1);
          end
        end
        SETTLE: begin
          // The product is captured on the MULT_LAT-th edge after the accept
          // edge, once the ripple array has had its full settle window.
          if (cnt == '0) begin
            rsp_product <= mul_product;
            rsp_valid   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl
//   Self-checking bench for mult_share_ctrl.
//   A behavioural multiplier closes the loop. A negedge monitor predicts every
//   grant from its own round-robin model and pushes the expected id and product
//   onto a scoreboard queue. Responses are popped and compared when they are
//   handed off.
//   The directed sequences cover these cases:
//     - single operations and operand extremes
//     - round-robin order
//     - backpressure
//     - reset in the middle of an operation
//     - back-to-back spacing

module tb_mult_share_ctrl;

  localparam int NREQ     = 4;
  localparam int MULT_LAT = 3;
  localparam int IDW      = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*16-1:0]  req_a;
  logic [NREQ*16-1:0]  req_b;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic [31:0]         mul_product;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_product;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mult_share_ctrl #(.NREQ(NREQ), .MULT_LAT(MULT_LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  // External multiplier: unsigned, full width.
  assign mul_product = {16'd0, mul_a} * {16'd0, mul_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and round-robin reference model.
  typedef struct {
    int          id;
    logic [31:0] prod;
  } exp_t;

  exp_t sb[$];
  int   model_last = NREQ - 1;

  always @(negedge clk) begin
    int              w;
    int              c;
    logic [NREQ-1:0] oh;
    logic [31:0]     p;
    exp_t            e;
    if (!rst_n) begin
      sb.delete();
      model_last = NREQ - 1;
    end else begin
      if (req_ready != '0) begin
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (model_last + k) % NREQ;
          if (w < 0 && req_valid[c]) w = c;
        end
        if (w < 0) begin
          check("grant_without_valid", 64'(req_ready), 64'd0);
        end else begin
          oh    = '0;
          oh[w] = 1'b1;
          check("grant", 64'(req_ready), 64'(oh));
          p = {16'd0, req_a[16*w +: 16]} * {16'd0, req_b[16*w +: 16]};
          e.id   = w;
          e.prod = p;
          sb.push_back(e);
          model_last = w;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_rsp_id", 64'(rsp_id), 64'(e.id));
          check("sb_rsp_product", 64'(rsp_product), 64'(e.prod));
        end
      end
    end
  end

  // Inputs change 1 time unit after a rising edge, well clear of the sampling
  // negedge and of the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int i, input string tag);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    check(tag, 64'(req_ready[i]), 64'd1);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  // One isolated operation with exact latency checks.
  // The first negedge after the accept edge is k=0.
  task automatic single_op(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp_p);
    step();
    rsp_ready = 1'b1;
    set_ops(i, a, b);
    req_valid[i] = 1'b1;
    wait_ready(i, "single_ready");
    step();
    req_valid[i] = 1'b0;
    for (int k = 0; k <= MULT_LAT; k++) begin
      @(negedge clk);
      check("single_latency", 64'(rsp_valid), 64'(k == MULT_LAT));
      check("single_busy", 64'(busy), 64'd1);
      check("single_mul_a", 64'(mul_a), 64'(a));
      if (k == 0) check("single_ready_pulse", 64'(req_ready), 64'd0);
    end
    check("single_product", 64'(rsp_product), 64'(exp_p));
    check("single_id", 64'(rsp_id), 64'(i));
    @(negedge clk);
    check("single_back_idle", 64'({rsp_valid, busy}), 64'd0);
  endtask

  initial begin
    int              seq[5];
    int              got;
    int              idle_cnt;
    int              last_acc;
    logic [31:0]     bp_exp;

    seq = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #1;
    check("reset_outputs",
          64'({req_ready, mul_a, mul_b, rsp_valid, rsp_id, busy}), 64'd0);
    check("reset_product", 64'(rsp_product), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Single operation, then operand extremes.
    single_op(0, 16'h04D2, 16'h162E, 32'h006A_E9BC);
    single_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    single_op(2, 16'h0000, 16'hBEEF, 32'h0000_0000);
    single_op(3, 16'h0001, 16'h8000, 32'h0000_8000);

    // Round-robin with all requesters held valid, starting from reset priority.
    step();
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'($urandom), 16'($urandom));
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (req_ready != '0) break;
      end
      got = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) got = i;
      check("rr_order", 64'(got), 64'(seq[n]));
      step();
      if (got >= 0) set_ops(got, 16'($urandom), 16'($urandom));
      if (n == 4) req_valid = '0;
    end
    drain("rr_drain");

    // Backpressure: the result is held in DONE with another requester waiting.
    step();
    rsp_ready = 1'b0;
    set_ops(3, 16'h1234, 16'h00FF);
    bp_exp = 32'h1234 * 32'h00FF;
    req_valid[3] = 1'b1;
    wait_ready(3, "bp_ready");
    step();
    req_valid[3] = 1'b0;
    req_valid[1] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    check("bp_rsp_arrives", 64'(rsp_valid), 64'd1);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_id", 64'(rsp_id), 64'd3);
      check("bp_hold_product", 64'(rsp_product), 64'(bp_exp));
      check("bp_no_ready", 64'(req_ready), 64'd0);
    end
    step();
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_released", 64'({rsp_valid, busy}), 64'd0);

    // Reset arriving one edge after an accept.
    step();
    rsp_ready = 1'b1;
    set_ops(0, 16'hABCD, 16'h0123);
    req_valid[0] = 1'b1;
    wait_ready(0, "rst_ready");
    step();
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_outputs_now",
          64'({req_ready, mul_a, mul_b, rsp_valid, rsp_id, busy}), 64'd0);
    check("rst_product_now", 64'(rsp_product), 64'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();
    rst_n = 1'b1;
    set_ops(1, 16'h0F0F, 16'h0003);
    set_ops(0, 16'h0002, 16'h0005);
    req_valid[1] = 1'b1;
    req_valid[0] = 1'b1;
    wait_ready(0, "rst_regrant_ready");
    check("rst_regrant_req0", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    drain("rst_drain");

    // Continuous req2 traffic: accepts exactly MULT_LAT+2 cycles apart, with
    // one idle cycle between them.
    step();
    rsp_ready = 1'b1;
    set_ops(2, 16'($urandom), 16'($urandom));
    req_valid[2] = 1'b1;
    last_acc = 0;
    for (int n = 0; n < 4; n++) begin
      idle_cnt = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (!busy) idle_cnt++;
        if (req_ready[2]) break;
      end
      check("sp_ready", 64'(req_ready[2]), 64'd1);
      if (n > 0) begin
        check("sp_spacing", 64'(cyc - last_acc), 64'(MULT_LAT + 2));
        check("sp_idle_cycles", 64'(idle_cnt), 64'd1);
      end
      last_acc = cyc;
      step();
      set_ops(2, 16'($urandom), 16'($urandom));
      if (n == 3) req_valid[2] = 1'b0;
    end
    drain("sp_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
